l2_arbiter: RTL and testbench
=============================

L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 i_read  in  1  I-cache line read request, held until i_resp.
REQ-004 i_address  in  16  I-cache line address.
REQ-005 i_rdata  out  128  line returned to I-cache.
REQ-006 i_resp  out  1  I-cache completion pulse.
REQ-007 d_read  in  1  D-cache line read request, held until d_resp.
REQ-008 d_write  in  1  D-cache line write-back request, held until d_resp.
REQ-009 d_address  in  16  D-cache line address.
REQ-010 d_wdata  in  128  D-cache write-back line.
REQ-011 d_rdata  out  128  line returned to D-cache.
REQ-012 d_resp  out  1  D-cache completion pulse.
REQ-013 l2_read  out  1  read request to L2, held until l2_resp.
REQ-014 l2_write  out  1  write request to L2, held until l2_resp.
REQ-015 l2_address  out  16  registered request address to L2.
REQ-016 l2_wdata  out  128  registered write line to L2.
REQ-017 l2_rdata  in  128  line from L2, valid when l2_resp=1.
REQ-018 l2_resp  in  1  L2 completion, one-cycle pulse.

Function
REQ-019 FSM states: IDLE, SERVE_I, SERVE_D; exactly one active.
REQ-020 IDLE: only i_read -> SERVE_I; only d_read|d_write -> SERVE_D; neither -> stay IDLE.
REQ-021 IDLE, both requesting: tie-break per REQ-036/REQ-037.
REQ-022 On the IDLE->SERVE_x edge, latch the requester's address (and d_wdata, and op) into l2_address/l2_wdata/op registers; later L1-side changes shall not affect them.
REQ-023 SERVE_I: l2_read=1, l2_write=0. SERVE_D: l2_read=latched d_read&~d_write, l2_write=latched d_write.
REQ-024 d_read and d_write both 1 at grant: treated as write.
REQ-025 Latency: request first seen in IDLE at cycle N -> l2_read/l2_write asserted at cycle N+1.
REQ-026 In SERVE_x with l2_resp=1: x_resp=1 same cycle (combinational), x_rdata=l2_rdata, next state IDLE.
REQ-027 The non-granted requester's resp shall be 0; rdata outputs are pass-through of l2_rdata at all times.
REQ-028 l2_read/l2_write deasserted in IDLE; one IDLE cycle minimum between consecutive L2 transactions.
REQ-029 l2_resp in IDLE ignored: no i_resp/d_resp, no state change.
REQ-030 A waiting requester is not dropped; it is granted on the next IDLE cycle in which it wins arbitration.
REQ-031 A granted requester is never preempted before l2_resp.

Reset
REQ-032 rst=1 at a clock edge: state IDLE, last_grant=I, address/wdata/op registers 0.
REQ-033 Outputs during/after reset: l2_read=0, l2_write=0, i_resp=0, d_resp=0, l2_address=16'h0000, l2_wdata=0.
REQ-034 Reset mid-transaction abandons it; an l2_resp arriving afterwards is ignored per REQ-029.
REQ-035 rst takes precedence over all other inputs in the same cycle.

Configuration
REQ-036 Macro ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, grant the requester not in last_grant; last_grant updates on every grant; first tie after reset goes to D.
REQ-037 Macro undefined: on a tie, D always wins (fixed priority); last_grant is not implemented.

Verification
REQ-038 Lone I read: i_read=1, i_address=16'h1230 at cycle 1 -> l2_read=1, l2_address=16'h1230 at cycle 2; l2_rdata=128'hA5..A5 with l2_resp at cycle 5 -> i_resp=1, i_rdata=128'hA5..A5 at cycle 5; IDLE at cycle 6.
REQ-039 D write-back: d_write=1, d_address=16'h8040, d_wdata=128'h0123..CDEF -> l2_write=1 and l2_wdata equals that value until l2_resp; d_resp pulses for exactly one cycle; i_resp stays 0.
REQ-040 Tie: i_read and d_read both 1 from cycle 1, each held until its resp -> first grant D (both configurations); after d_resp, I granted with RR, D granted again without RR if d_read is reasserted.
REQ-041 Address stability: change d_address 16'h0100->16'h0200 one cycle after grant -> l2_address remains 16'h0100 until l2_resp.
REQ-042 Reset mid-transaction: rst=1 while SERVE_I, then l2_resp=1 one cycle after rst releases -> l2_read=0, no i_resp, state IDLE.
REQ-043 Spurious l2_resp in IDLE with no requests -> i_resp=d_resp=0, l2_read=l2_write=0.

Source files
------------

// File: rtl/l2_arbiter.sv
// Shares one L2 port between I-cache and D-cache. The L2 request starts one cycle after the request is seen; resp and rdata pass back in the same cycle as l2_resp.
// Backpressure: the losing requester holds its request until served. Ties favour D unless ARB_ROUND_ROBIN_EN is defined; then ties alternate.
module l2_arbiter (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_read,
   input  logic [15:0]  i_address,
   output logic [127:0] i_rdata,
   output logic         i_resp,
   input  logic         d_read,
   input  logic         d_write,
   input  logic [15:0]  d_address,
   input  logic [127:0] d_wdata,
   output logic [127:0] d_rdata,
   output logic         d_resp,
   output logic         l2_read,
   output logic         l2_write,
   output logic [15:0]  l2_address,
   output logic [127:0] l2_wdata,
   input  logic [127:0] l2_rdata,
   input  logic         l2_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [15:0]    addr_q, addr_d;
   logic [127:0]   wdata_q, wdata_d;
   logic           wr_q, wr_d;
   logic           i_req, d_req, tie_to_d, pick_d;

`ifdef ARB_ROUND_ROBIN_EN
   // High when the most recent grant went to D.
   logic           last_d_q, last_d_d;
`endif

   always_comb begin
      i_req = i_read;
      d_req = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
      tie_to_d = ~last_d_q;
`else
      tie_to_d = 1'b1;
`endif
      pick_d = d_req & (~i_req | tie_to_d);
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_d = last_d_q;
`endif
      i_resp   = 1'b0;
      d_resp   = 1'b0;
      l2_read  = 1'b0;
      l2_write = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d  = SERVE_D;
               addr_d   = d_address;
               wdata_d  = d_wdata;
               // A simultaneous read and write is served as a write-back.
               wr_d     = d_write;
`ifdef ARB_ROUND_ROBIN_EN
               last_d_d = 1'b1;
`endif
            end else if (i_req) begin
               state_d  = SERVE_I;
               addr_d   = i_address;
               wr_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
               last_d_d = 1'b0;
`endif
            end
         end
         SERVE_I: begin
            l2_read = 1'b1;
            if (l2_resp) begin
               i_resp  = 1'b1;
               state_d = IDLE;
            end
         end
         SERVE_D: begin
            l2_read  = ~wr_q;
            l2_write = wr_q;
            if (l2_resp) begin
               d_resp  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= 16'h0000;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q <= last_d_d;
`endif
      end
   end

   assign l2_address = addr_q;
   assign l2_wdata   = wdata_q;
   assign i_rdata    = l2_rdata;
   assign d_rdata    = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Random traffic bench for l2_arbiter: the driver models requesters, L2 and the arbitration rules; a monitor pops expected events per cycle.
module tb_l2_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i_read = 1'b0;
   logic [15:0]  i_address = '0;
   logic [127:0] i_rdata;
   logic         i_resp;
   logic         d_read = 1'b0;
   logic         d_write = 1'b0;
   logic [15:0]  d_address = '0;
   logic [127:0] d_wdata = '0;
   logic [127:0] d_rdata;
   logic         d_resp;
   logic         l2_read;
   logic         l2_write;
   logic [15:0]  l2_address;
   logic [127:0] l2_wdata;
   logic [127:0] l2_rdata = '0;
   logic         l2_resp = 1'b0;

   always #5 clk = ~clk;

   l2_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .i_read     (i_read),
      .i_address  (i_address),
      .i_rdata    (i_rdata),
      .i_resp     (i_resp),
      .d_read     (d_read),
      .d_write    (d_write),
      .d_address  (d_address),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_resp     (d_resp),
      .l2_read    (l2_read),
      .l2_write   (l2_write),
      .l2_address (l2_address),
      .l2_wdata   (l2_wdata),
      .l2_rdata   (l2_rdata),
      .l2_resp    (l2_resp)
   );

   typedef struct {
      int           cyc;
      logic         rd;
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
      logic         chk_w;
   } l2_exp_t;

   typedef struct {
      int           cyc;
      logic [1:0]   who;
      logic [127:0] rdata;
   } rsp_exp_t;

   localparam logic [1:0] WHO_I = 2'b10;
   localparam logic [1:0] WHO_D = 2'b01;

   l2_exp_t  exp_l2[$];
   rsp_exp_t exp_rsp[$];
   int       n_chk = 0;
   int       n_fail = 0;
   int       cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference model state: requesters, arbiter occupancy and tie history.
   logic       m_busy, m_last_d;
   int         m_gcyc;
   logic [1:0] m_who;
   logic       i_busy, i_pend, i_done;
   logic       d_busy, d_pend, d_done;
   int         rst_cnt = 3;

   task automatic model_reset();
      m_busy = 1'b0; m_last_d = 1'b0; m_gcyc = 0; m_who = 2'b00;
      i_busy = 1'b0; i_pend = 1'b0; i_done = 1'b0;
      d_busy = 1'b0; d_pend = 1'b0; d_done = 1'b0;
   endtask

   task automatic step(input bit gen);
      int      c;
      int      d_op;
      bit      win_d;
      l2_exp_t e;
      c = cyc;
      l2_rdata = rnd128();
      if (rst_cnt == 0 && gen && $urandom_range(0, 199) == 0) rst_cnt = $urandom_range(1, 3);
      if (rst_cnt > 0) begin
         rst = 1'b1; rst_cnt--;
         i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
         model_reset();
         return;
      end
      rst = 1'b0;
      if (i_done) begin i_read = 1'b0; i_busy = 1'b0; i_done = 1'b0; end
      if (d_done) begin d_read = 1'b0; d_write = 1'b0; d_busy = 1'b0; d_done = 1'b0; end
      if (!i_busy && gen && $urandom_range(0, 3) == 0) begin
         i_busy = 1'b1; i_pend = 1'b1; i_read = 1'b1; i_address = 16'($urandom);
      end else if (i_busy && $urandom_range(0, 2) == 0) begin
         i_address = 16'($urandom);
      end
      if (!d_busy && gen && $urandom_range(0, 3) == 0) begin
         d_op = $urandom_range(0, 2);  // 0 read, 1 write, 2 both
         d_busy = 1'b1; d_pend = 1'b1;
         d_read = (d_op != 1); d_write = (d_op != 0);
         d_address = 16'($urandom); d_wdata = rnd128();
      end else if (d_busy && $urandom_range(0, 2) == 0) begin
         d_address = 16'($urandom); d_wdata = rnd128();
      end
      // A free arbiter serves one waiting requester; a tie goes to D unless alternating.
      if (!m_busy && (i_pend || d_pend)) begin
         if (i_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d = !m_last_d;
`else
            win_d = 1'b1;
`endif
         end else begin
            win_d = d_pend;
         end
         e.cyc = c + 1;
         if (win_d) begin
            e.rd = d_read && !d_write; e.wr = d_write;
            e.addr = d_address; e.wdata = d_wdata; e.chk_w = 1'b1;
            m_who = WHO_D; d_pend = 1'b0;
         end else begin
            e.rd = 1'b1; e.wr = 1'b0;
            e.addr = i_address; e.wdata = '0; e.chk_w = 1'b0;
            m_who = WHO_I; i_pend = 1'b0;
         end
         exp_l2.push_back(e);
         m_busy = 1'b1; m_gcyc = c; m_last_d = win_d;
      end
      l2_resp = 1'b0;
      if (m_busy && c > m_gcyc) begin
         if ($urandom_range(0, 2) == 0) begin
            l2_resp = 1'b1;
            exp_rsp.push_back('{c, m_who, l2_rdata});
            m_busy = 1'b0;
            if (m_who == WHO_I) i_done = 1'b1; else d_done = 1'b1;
         end
      end else if ($urandom_range(0, 5) == 0) begin
         l2_resp = 1'b1;  // arbiter idle: must be ignored
      end
   endtask

   initial begin
      model_reset();
      for (int k = 0; k < 4000; k++) begin
         @(posedge clk); #1;
         step(1'b1);
      end
      for (int k = 0; k < 150; k++) begin
         @(posedge clk); #1;
         step(1'b0);
      end
      @(posedge clk); #5;
      chk("l2_queue_drained", 128'(exp_l2.size()), 128'(0));
      chk("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      logic     act, rise;
      logic     prev_act = 1'b0;
      logic     prev_rst = 1'b0;
      logic     prev_rsp = 1'b0;
      logic     cur_v = 1'b0;
      l2_exp_t  cur;
      l2_exp_t  e;
      rsp_exp_t r;
      forever begin
         @(posedge clk); #3;
         act  = l2_read | l2_write;
         rise = act & ~prev_act;
         if (prev_rst) begin
            chk("reset_ctrl", 128'({l2_read, l2_write, i_resp, d_resp}), 128'(0));
            chk("reset_l2_address", 128'(l2_address), 128'(0));
            chk("reset_l2_wdata", l2_wdata, 128'(0));
            cur_v = 1'b0;
         end
         if (exp_l2.size() > 0 && exp_l2[0].cyc == cyc) begin
            e = exp_l2.pop_front();
            chk("l2_start", 128'(rise), 128'(1));
            chk("l2_read", 128'(l2_read), 128'(e.rd));
            chk("l2_write", 128'(l2_write), 128'(e.wr));
            chk("l2_address", 128'(l2_address), 128'(e.addr));
            if (e.chk_w) chk("l2_wdata", l2_wdata, e.wdata);
            cur = e; cur_v = 1'b1;
         end else begin
            chk("l2_unexpected_start", 128'(rise), 128'(0));
            if (act && cur_v) begin
               chk("l2_address_stable", 128'(l2_address), 128'(cur.addr));
               chk("l2_op_stable", 128'({l2_read, l2_write}), 128'({cur.rd, cur.wr}));
               if (cur.chk_w) chk("l2_wdata_stable", l2_wdata, cur.wdata);
            end
         end
         if (exp_rsp.size() > 0 && exp_rsp[0].cyc == cyc) begin
            r = exp_rsp.pop_front();
            chk("resp_who", 128'({i_resp, d_resp}), 128'(r.who));
            chk("resp_rdata", (r.who == WHO_I) ? i_rdata : d_rdata, r.rdata);
         end else begin
            chk("resp_none", 128'({i_resp, d_resp}), 128'(0));
         end
         if (prev_rsp) chk("idle_gap", 128'(act), 128'(0));
         chk("i_rdata_pass", i_rdata, l2_rdata);
         chk("d_rdata_pass", d_rdata, l2_rdata);
         prev_act = act;
         prev_rst = rst;
         prev_rsp = i_resp | d_resp;
      end
   end

endmodule
